axis_seq_checker: RTL and testbench
===================================

AXIS_SEQ_CHECKER -- requirements
Module: axis_seq_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32: stream data width in bits.
REQ-002 Parameter LEN_WIDTH, default 16: width of the beat-length and beat-count fields.
REQ-003 Parameter ERR_WIDTH, default 16: width of the error counter.
REQ-004 Port aclk, input, 1: the single clock; all logic is rising-edge.
REQ-005 Port aresetn, input, 1: reset; synchronous, active-low.
REQ-006 Port s_data, input, DATA_WIDTH: AXI-Stream slave data from the upstream fifo_axi m_data.
REQ-007 Port s_valid, input, 1: AXI-Stream slave valid.
REQ-008 Port s_ready, output, 1: AXI-Stream slave ready; a registered output.
REQ-009 Port start, input, 1: single-cycle pulse that begins a check run.
REQ-010 Port first_val, input, DATA_WIDTH: expected value of the first beat; sampled on start.
REQ-011 Port len, input, LEN_WIDTH: number of beats to accept; sampled on start.
REQ-012 Port throttle_en, input, 1: when 1, s_ready is gated by the LFSR; sampled on start.
REQ-013 Port seed, input, 16: LFSR seed; sampled on start.
REQ-014 Port busy, output, 1: high in the RUN state.
REQ-015 Port done, output, 1: high in the DONE state.
REQ-016 Port beat_count, output, LEN_WIDTH: number of handshakes accepted in the current run.
REQ-017 Port err_count, output, ERR_WIDTH: number of data mismatches; saturates at all-ones.
REQ-018 Port first_err_idx, output, LEN_WIDTH: beat index (0-based) of the first mismatch.
REQ-019 Port first_err_data, output, DATA_WIDTH: received data of the first mismatch.
REQ-020 Port proto_err, output, 1: sticky AXI-Stream protocol violation flag.

Function
REQ-021 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
REQ-022 On start in IDLE or DONE, the block SHALL load expected=first_val and remaining=len, and SHALL clear beat_count, err_count, first_err_idx, first_err_data and proto_err.
REQ-023 On start with len=0, the FSM SHALL go to DONE on the next cycle and SHALL accept no beats.
REQ-024 On start with len>0, the FSM SHALL go to RUN.
REQ-025 A start pulse in RUN SHALL be ignored.
REQ-026 In RUN with throttle_en=0, s_ready SHALL be 1 from the cycle after entry.
REQ-027 In RUN with throttle_en=1, s_ready SHALL be registered from LFSR bit 0, and the LFSR SHALL advance every RUN cycle.
REQ-028 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
REQ-029 A seed of 0 SHALL be replaced by 16'hACE1.
REQ-030 s_ready SHALL be 0 in IDLE and DONE.
REQ-031 s_ready SHALL deassert in the same cycle the last beat is accepted.
REQ-032 A beat is accepted only when s_valid and s_ready are both 1 at a rising edge.
REQ-033 On each accepted beat, the block SHALL compare s_data with expected.
REQ-034 On a mismatch, err_count SHALL increment, saturating at all-ones.
REQ-035 On the first mismatch of a run, first_err_idx and first_err_data SHALL be captured.
REQ-036 On each accepted beat, expected SHALL increment modulo 2^DATA_WIDTH, so all-ones wraps to 0 with no error.
REQ-037 On each accepted beat, beat_count SHALL increment and remaining SHALL decrement.
REQ-038 When the beat with remaining=1 is accepted, the FSM SHALL go to DONE on the next cycle.
REQ-039 In DONE, the FSM SHALL hold all statistics until the next start.
REQ-040 The protocol monitor SHALL be active in RUN only.
REQ-041 The monitor SHALL set proto_err if, in a cycle where s_valid=1 and s_ready=0, the next cycle has s_valid=0.
REQ-042 The monitor SHALL set proto_err if, in a cycle where s_valid=1 and s_ready=0, s_data changes on the next cycle.
REQ-043 proto_err SHALL be cleared only by reset or by start.
REQ-044 Input data beyond len SHALL be neither accepted nor counted.

Reset
REQ-045 On aresetn=0 at a rising edge, the block SHALL enter IDLE within that cycle.
REQ-046 On reset, s_ready, busy, done and proto_err SHALL be 0.
REQ-047 On reset, all counters and capture registers SHALL be 0, and the LFSR SHALL be 16'hACE1.
REQ-048 Reset asserted mid-run SHALL abort the run and drop s_ready on the next edge, with no beat accepted on that edge.

Structure
REQ-049 Package axis_chk_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), LFSR_MASK=16'hB400 and LFSR_DEFAULT_SEED=16'hACE1.
REQ-050 The LFSR SHALL be the sub-module lfsr16, with ports aclk, aresetn, load, seed, en and q.
REQ-051 The comparator, counters and protocol monitor SHALL be inline in axis_seq_checker.

Verification
REQ-052 The bench SHALL cover: first_val=0, len=16, throttle_en=0, source sends 0..15 back-to-back -> beat_count=16, err_count=0, done=1, s_ready=0 after the last beat.
REQ-053 The bench SHALL cover: first_val=32'hFFFF_FFFE, len=4, data FFFF_FFFE, FFFF_FFFF, 0, 1 -> err_count=0.
REQ-054 The bench SHALL cover: len=8, data 0..7 with beat 5 sent as 32'hDEAD -> err_count=1, first_err_idx=5, first_err_data=32'hDEAD.
REQ-055 The bench SHALL cover: throttle_en=1, seed=0, len=32, random s_valid gaps -> 32 beats accepted in order, err_count=0, s_ready never high in DONE.
REQ-056 The bench SHALL cover: source drops s_valid while s_ready=0 -> proto_err=1 held until the next start.
REQ-057 The bench SHALL cover: reset pulsed after 3 of 10 beats, then start with len=2 -> after reset all outputs are 0, and the new run ends with beat_count=2.

Source files
------------

// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-Stream sequence checker: FSM encoding and
// the LFSR constants used for ready throttling.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One right-shift Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with load and enable; a zero seed would lock the
// register at zero, so it is replaced by the default seed.
module lfsr16
  import axis_chk_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      r_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (en) begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks an incrementing data sequence, counts beats and
// mismatches, optionally throttles ready from an LFSR and flags protocol errors.
module axis_seq_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] first_val,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  throttle_en,
  input  logic [15:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_count,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [LEN_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  proto_err
);

  localparam logic [15:0] READY_TAP = 16'h0001;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_expected;
  logic [DATA_WIDTH-1:0] r_first_err_data;
  logic [DATA_WIDTH-1:0] r_prev_data;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  r_beat_count;
  logic [LEN_WIDTH-1:0]  r_first_err_idx;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic                  r_ready;
  logic                  r_throttle;
  logic                  r_proto_err;
  logic                  r_stall;

  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_mismatch;
  logic                  w_violation;
  logic                  w_lfsr_tap;
  logic [15:0]           w_lfsr_q;

  assign w_start_ok  = start && (r_state != RUN);
  assign w_accept    = (r_state == RUN) && s_valid && r_ready;
  assign w_last      = w_accept && (r_remaining == LEN_WIDTH'(1));
  assign w_mismatch  = w_accept && (s_data != r_expected);
  // A stalled beat must stay valid with unchanged data until it is taken.
  assign w_violation = (r_state == RUN) && r_stall &&
                       (!s_valid || (s_data != r_prev_data));
  assign w_lfsr_tap  = |(w_lfsr_q & READY_TAP);

  lfsr16 u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (w_start_ok),
    .seed    (seed),
    .en      (r_state == RUN),
    .q       (w_lfsr_q)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready drops on the edge that takes the final beat, so nothing past len is accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ready <= 1'b0;
    end else if ((r_state == RUN) && !w_last) begin
      r_ready <= r_throttle ? w_lfsr_tap : 1'b1;
    end else begin
      r_ready <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_expected       <= '0;
      r_remaining      <= '0;
      r_beat_count     <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_throttle       <= 1'b0;
      r_proto_err      <= 1'b0;
      r_stall          <= 1'b0;
    end else if (w_start_ok) begin
      r_expected       <= first_val;
      r_remaining      <= len;
      r_beat_count     <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
      r_throttle       <= throttle_en;
      r_proto_err      <= 1'b0;
      r_stall          <= 1'b0;
    end else begin
      if (w_accept) begin
        r_expected   <= r_expected + DATA_WIDTH'(1);
        r_remaining  <= r_remaining - LEN_WIDTH'(1);
        r_beat_count <= r_beat_count + LEN_WIDTH'(1);
      end
      if (w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
        if (r_err_count == '0) begin
          r_first_err_idx  <= r_beat_count;
          r_first_err_data <= s_data;
        end
      end
      r_stall <= (r_state == RUN) && s_valid && !r_ready;
      if (w_violation) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    r_prev_data <= s_data;
  end

  assign s_ready        = r_ready;
  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign beat_count     = r_beat_count;
  assign err_count      = r_err_count;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_data = r_first_err_data;
  assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Bench for axis_seq_checker: vector table, hand-written corner sequences and
// randomized runs scored against a behavioural model of the expected sequence.
module tb_axis_seq_checker;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int EW = 4;
  localparam int ERR_MAX = 15;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          start;
  logic [DW-1:0] first_val;
  logic [LW-1:0] len;
  logic          throttle_en;
  logic [15:0]   seed;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_count;
  logic [EW-1:0] err_count;
  logic [LW-1:0] first_err_idx;
  logic [DW-1:0] first_err_data;
  logic          proto_err;

  axis_seq_checker #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .ERR_WIDTH  (EW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .start          (start),
    .first_val      (first_val),
    .len            (len),
    .throttle_en    (throttle_en),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .beat_count     (beat_count),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data),
    .proto_err      (proto_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] fv;
    int          n;
    logic        thr;
    logic [15:0] sd;
    int          gap;
    int          cmode;   // 0 clean, 1 one corrupted beat, 2 all beats inverted
    int          cidx;
    logic [31:0] cval;
    int          extra;
    int          viol;    // 0 none, 1 drop valid while stalled, 2 change data while stalled
    int          rs_cyc;
    int          e_beats;
    int          e_err;
    int          e_idx;
    logic [31:0] e_data;
    logic        e_proto;
  } vec_t;

  vec_t        vt [9];
  logic [31:0] src [$];
  logic [31:0] d;
  logic [31:0] e_data;
  logic [31:0] rfv;
  logic [15:0] q;
  int          n_acc, e_err, e_idx, bad, k, rn;
  logic        hs;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] fv, input logic [15:0] l,
                          input logic thr, input logic [15:0] sd);
    first_val   = fv;
    len         = l;
    throttle_en = thr;
    seed        = sd;
    start       = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  // Source that honours AXI-Stream hold rules unless told to break them in its first two cycles.
  task automatic run_stream(input logic [31:0] s[$], input int gap, input int viol,
                            input int rs_cyc, output int acc);
    logic h;
    int post, rdy_done, order_bad;
    h = 1'b0; post = 0; rdy_done = 0; order_bad = 0; acc = 0;
    for (int cyc = 0; cyc < 3000 && post < 4; cyc++) begin
      if (h) begin
        if (acc >= s.size() || s_data !== s[acc]) order_bad++;
        acc++;
      end
      if (!(s_valid && !h)) begin
        if (acc < s.size() && $urandom_range(99) >= gap) begin
          s_valid = 1'b1;
          s_data  = s[acc];
        end else begin
          s_valid = 1'b0;
        end
      end
      if (viol != 0 && cyc == 0) begin
        s_valid = 1'b1;
        s_data  = (viol == 2) ? ~s[0] : s[0];
      end
      if (viol == 1 && cyc == 1) s_valid = 1'b0;
      if (viol == 2 && cyc == 1) begin
        s_valid = 1'b1;
        s_data  = s[0];
      end
      start = (cyc == rs_cyc);
      if (cyc == rs_cyc) begin
        first_val = 32'h5555_5555;
        len       = 16'd1;
      end
      if (done) begin
        post++;
        if (s_ready) rdy_done++;
      end
      h = s_valid && s_ready;
      @(negedge aclk);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("stream_reached_done", 64'(post >= 4), 64'd1);
    chk("accept_order", 64'(order_bad), 64'd0);
    chk("ready_in_done", 64'(rdy_done), 64'd0);
  endtask

  task automatic check_run(input string p, input int eb, input int ee, input int ei,
                           input logic [31:0] ed, input logic ep, input int acc);
    chk({p, "_beat_count"}, 64'(beat_count), 64'(eb));
    chk({p, "_handshakes"}, 64'(acc), 64'(eb));
    chk({p, "_err_count"}, 64'(err_count), 64'(ee));
    chk({p, "_first_err_idx"}, 64'(first_err_idx), 64'(ei));
    chk({p, "_first_err_data"}, 64'(first_err_data), 64'(ed));
    chk({p, "_proto_err"}, 64'(proto_err), 64'(ep));
    chk({p, "_done"}, 64'(done), 64'd1);
    chk({p, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Expected statistics straight from the rules: beat i should equal fv+i mod 2^32.
  function automatic void ref_model(input logic [31:0] fv, input int n, input logic [31:0] s[$],
                                    output int ee, output int ei, output logic [31:0] ed);
    ee = 0; ei = 0; ed = '0;
    for (int i = 0; i < n; i++) begin
      if (s[i] !== fv + 32'(i)) begin
        if (ee == 0) begin
          ei = i;
          ed = s[i];
        end
        if (ee < ERR_MAX) ee++;
      end
    end
  endfunction

  function automatic void build_seq(input logic [31:0] fv, input int cnt, output logic [31:0] s[$]);
    s = {};
    for (int i = 0; i < cnt; i++) s.push_back(fv + 32'(i));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        fv            n   thr  seed      gap cm cidx cval          ex viol rs  beats err idx data          proto
    vt[0] = '{32'h0000_0000, 16, 1'b0, 16'h0000, 0,  0, 0,   32'h0,        2, 0,   -1, 16,   0,  0,  32'h0,        1'b0};
    vt[1] = '{32'hFFFF_FFFE, 4,  1'b0, 16'h0000, 0,  0, 0,   32'h0,        1, 0,   -1, 4,    0,  0,  32'h0,        1'b0};
    vt[2] = '{32'h0000_0000, 8,  1'b0, 16'h0000, 0,  1, 5,   32'h0000_DEAD, 0, 0,  -1, 8,    1,  5,  32'h0000_DEAD, 1'b0};
    vt[3] = '{32'h0000_1000, 32, 1'b1, 16'h0000, 30, 0, 0,   32'h0,        2, 0,   -1, 32,   0,  0,  32'h0,        1'b0};
    vt[4] = '{32'h0000_0005, 0,  1'b0, 16'h0000, 0,  0, 0,   32'h0,        3, 0,   -1, 0,    0,  0,  32'h0,        1'b0};
    vt[5] = '{32'h0000_0000, 20, 1'b1, 16'h00FF, 10, 2, 0,   32'h0,        0, 0,   -1, 20,   15, 0,  32'hFFFF_FFFF, 1'b0};
    vt[6] = '{32'h0000_0080, 5,  1'b1, 16'hBEEF, 20, 1, 4,   32'h0,        1, 0,   -1, 5,    1,  4,  32'h0,        1'b0};
    vt[7] = '{32'h0000_0040, 3,  1'b0, 16'h0000, 0,  0, 0,   32'h0,        0, 1,   -1, 3,    0,  0,  32'h0,        1'b1};
    vt[8] = '{32'h0000_0200, 6,  1'b0, 16'h0000, 0,  0, 0,   32'h0,        1, 2,   3,  6,    0,  0,  32'h0,        1'b1};

    aresetn = 1'b0; s_data = '0; s_valid = 1'b0; start = 1'b0;
    first_val = '0; len = '0; throttle_en = 1'b0; seed = '0;
    repeat (3) @(negedge aclk);

    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_counts", 64'({beat_count, 12'(err_count), first_err_idx}), 64'd0);
    chk("rst_err_data", 64'(first_err_data), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_after_rst", 64'({busy, done, s_ready}), 64'd0);

    for (int r = 0; r < 9; r++) begin
      src.delete();
      for (int i = 0; i < vt[r].n + vt[r].extra; i++) begin
        d = vt[r].fv + 32'(i);
        if (vt[r].cmode == 1 && i == vt[r].cidx) d = vt[r].cval;
        else if (vt[r].cmode == 2) d = ~d;
        src.push_back(d);
      end
      do_start(vt[r].fv, 16'(vt[r].n), vt[r].thr, vt[r].sd);
      run_stream(src, vt[r].gap, vt[r].viol, vt[r].rs_cyc, n_acc);
      check_run($sformatf("vec%0d", r), vt[r].e_beats, vt[r].e_err, vt[r].e_idx,
                vt[r].e_data, vt[r].e_proto, n_acc);
    end

    // Ready stays low in the entry cycle and rises one cycle later when unthrottled.
    do_start(32'h10, 16'd3, 1'b0, 16'h0);
    chk("entry_busy", 64'(busy), 64'd1);
    chk("entry_ready_low", 64'(s_ready), 64'd0);
    @(negedge aclk);
    chk("entry_ready_high", 64'(s_ready), 64'd1);
    build_seq(32'h10, 3, src);
    run_stream(src, 0, 0, -1, n_acc);
    check_run("entry", 3, 0, 0, 32'h0, 1'b0, n_acc);

    // Throttled ready follows bit 0 of the LFSR, one register stage behind it.
    for (int t = 0; t < 2; t++) begin
      d = (t == 0) ? 32'h0 : 32'h1234;
      do_start(32'h0, 16'd4, 1'b1, d[15:0]);
      q = (d[15:0] == 16'h0) ? 16'hACE1 : d[15:0];
      bad = 0;
      @(negedge aclk);
      for (int j = 0; j < 24; j++) begin
        if (s_ready !== q[0]) bad++;
        q = (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
        @(negedge aclk);
      end
      chk($sformatf("lfsr_ready_seq%0d", t), 64'(bad), 64'd0);
      build_seq(32'h0, 4, src);
      run_stream(src, 0, 0, -1, n_acc);
      check_run($sformatf("lfsr%0d", t), 4, 0, 0, 32'h0, 1'b0, n_acc);
    end

    // Protocol error and statistics stay latched in DONE; a new start clears them.
    build_seq(32'h300, 4, src);
    src[1] = 32'hBAD0_0001;
    do_start(32'h300, 16'd4, 1'b0, 16'h0);
    run_stream(src, 0, 1, -1, n_acc);
    check_run("proto", 4, 1, 1, 32'hBAD0_0001, 1'b1, n_acc);
    repeat (5) @(negedge aclk);
    chk("proto_held_done", 64'(proto_err), 64'd1);
    chk("err_held_done", 64'(err_count), 64'd1);
    chk("beats_held_done", 64'(beat_count), 64'd4);
    do_start(32'h0, 16'd2, 1'b0, 16'h0);
    chk("start_clears_proto", 64'(proto_err), 64'd0);
    chk("start_clears_stats", 64'({beat_count, 12'(err_count), first_err_idx}), 64'd0);
    chk("start_clears_data", 64'(first_err_data), 64'd0);
    build_seq(32'h0, 2, src);
    run_stream(src, 0, 0, -1, n_acc);
    check_run("after_proto", 2, 0, 0, 32'h0, 1'b0, n_acc);

    // Reset in the middle of a run aborts it without taking the presented beat.
    do_start(32'h0, 16'd10, 1'b0, 16'h0);
    s_valid = 1'b1; s_data = 32'h0; k = 0;
    for (int c = 0; c < 100 && k < 3; c++) begin
      hs = s_ready;
      @(negedge aclk);
      if (hs) begin
        k++;
        s_data = 32'(k);
      end
    end
    chk("pre_reset_beats", 64'(beat_count), 64'd3);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    s_valid = 1'b0;
    chk("midrst_ready", 64'(s_ready), 64'd0);
    chk("midrst_state", 64'({busy, done}), 64'd0);
    chk("midrst_counts", 64'({beat_count, 12'(err_count), first_err_idx}), 64'd0);
    chk("midrst_data_proto", 64'({first_err_data, 31'd0, proto_err}), 64'd0);
    do_start(32'd100, 16'd2, 1'b0, 16'h0);
    build_seq(32'd100, 3, src);
    run_stream(src, 0, 0, -1, n_acc);
    check_run("post_rst", 2, 0, 0, 32'h0, 1'b0, n_acc);

    // Randomized runs scored against the reference model.
    for (int r = 0; r < 10; r++) begin
      rfv = $urandom;
      if (r == 0) rfv = 32'hFFFF_FFF8;
      rn = $urandom_range(24, 1);
      src.delete();
      for (int i = 0; i < rn + int'($urandom_range(3, 0)); i++) begin
        d = rfv + 32'(i);
        if ($urandom_range(99) < 25) d = $urandom;
        src.push_back(d);
      end
      ref_model(rfv, rn, src, e_err, e_idx, e_data);
      do_start(rfv, 16'(rn), 1'($urandom_range(1, 0)), 16'($urandom));
      run_stream(src, int'($urandom_range(50, 0)), 0, -1, n_acc);
      check_run($sformatf("rand%0d", r), rn, e_err, e_idx, e_data, 1'b0, n_acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
